// File: rtl/drain_flow_monitor.sv
// Drain-path supervisor: confirms an empty drum, or latches a drainage fault
// when the level stops falling or draining takes too long.
module drain_flow_monitor #(
  parameter int CHECK_PERIOD  = 10,
  parameter int MIN_DROP      = 5,
  parameter int STALL_LIMIT   = 3,
  parameter int EMPTY_LEVEL   = 10,
  parameter int EMPTY_CONFIRM = 4,
  parameter int TIMEOUT       = 600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       drain_pump,
  input  logic [9:0] water_level_sensor,
  input  logic       clear_error,
  output logic       drain_done,
  output logic       error_flag,
  output logic       drainage_error_led,
  output logic [1:0] stall_count,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DRAINING = 2'd1,
    EMPTY    = 2'd2,
    ERROR    = 2'd3
  } state_t;

  localparam int PW = $clog2(CHECK_PERIOD);
  localparam int EW = $clog2(EMPTY_CONFIRM + 1);

  localparam logic [PW-1:0] P_LAST = PW'(CHECK_PERIOD - 1);
  localparam logic [EW-1:0] E_LAST = EW'(EMPTY_CONFIRM - 1);
  localparam logic [15:0]   T_LAST = 16'(TIMEOUT - 1);
  localparam logic [1:0]    S_MAX  = 2'(STALL_LIMIT);
  localparam logic [9:0]    E_LVL  = 10'(EMPTY_LEVEL);
  localparam logic [9:0]    M_DROP = 10'(MIN_DROP);

  state_t        state_q, state_d;
  logic [9:0]    prev_q, prev_d;
  logic [PW-1:0] period_q, period_d;
  logic [1:0]    stall_q, stall_d;
  logic [EW-1:0] empty_q, empty_d;
  logic [15:0]   tmo_q, tmo_d;
  logic          done_q, err_q, led_q;

  logic [9:0] level;
  logic [9:0] drop;
  logic [1:0] stall_inc;
  logic       low;
  logic       check;
  logic       slow;
  logic       empty_hit;
  logic       stalled;
  logic       timed_out;
  logic       clr;

  assign level     = water_level_sensor;
  assign low       = level <= E_LVL;
  assign check     = period_q == P_LAST;
  assign drop      = (prev_q > level) ? prev_q - level : '0;
  assign slow      = drop < M_DROP;
  assign stall_inc = (stall_q == S_MAX) ? stall_q : stall_q + 2'd1;
  assign empty_hit = low && (empty_q == E_LAST);
  assign stalled   = check && slow && (stall_inc == S_MAX);
  assign timed_out = tmo_q == T_LAST;

  always_comb begin
    state_d  = state_q;
    prev_d   = prev_q;
    period_d = period_q;
    stall_d  = stall_q;
    empty_d  = empty_q;
    tmo_d    = tmo_q;
    clr      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (drain_pump) begin
          state_d = DRAINING;
          clr     = 1'b1;
        end
      end
      DRAINING: begin
        if (!drain_pump) begin
          state_d = IDLE;
          clr     = 1'b1;
        end else begin
          tmo_d    = tmo_q + 16'd1;
          period_d = check ? '0 : period_q + PW'(1);
          empty_d  = low ? empty_q + EW'(1) : '0;
          if (check) begin
            prev_d  = level;
            stall_d = slow ? stall_inc : '0;
          end
          // empty confirmation outranks both fault causes
          if (empty_hit)      state_d = EMPTY;
          else if (stalled)   state_d = ERROR;
          else if (timed_out) state_d = ERROR;
        end
      end
      EMPTY: begin
        if (!drain_pump) begin
          state_d = IDLE;
          clr     = 1'b1;
        end
      end
      ERROR: begin
        if (clear_error && !drain_pump) begin
          state_d = IDLE;
          clr     = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        clr     = 1'b1;
      end
    endcase
    if (clr) begin
      prev_d   = drain_pump ? level : '0;
      period_d = '0;
      stall_d  = '0;
      empty_d  = '0;
      tmo_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      prev_q   <= '0;
      period_q <= '0;
      stall_q  <= '0;
      empty_q  <= '0;
      tmo_q    <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      led_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      prev_q   <= prev_d;
      period_q <= period_d;
      stall_q  <= stall_d;
      empty_q  <= empty_d;
      tmo_q    <= tmo_d;
      done_q   <= state_d == EMPTY;
      err_q    <= state_d == ERROR;
      led_q    <= state_d == ERROR;
    end
  end

  assign drain_done         = done_q;
  assign error_flag         = err_q;
  assign drainage_error_led = led_q;
  assign stall_count        = stall_q;
  assign state              = state_q;

endmodule

// File: tb/tb_drain_flow_monitor.sv
// Bench for drain_flow_monitor: directed table, hand sequences and random
// stimulus against a history-based reference model.
module tb_drain_flow_monitor;

  localparam int CP = 10;
  localparam int MD = 5;
  localparam int SL = 3;
  localparam int EL = 10;
  localparam int EC = 4;
  localparam int TO = 600;

  logic       clk;
  logic       reset;
  logic       drain_pump;
  logic [9:0] water_level_sensor;
  logic       clear_error;
  logic       drain_done;
  logic       error_flag;
  logic       drainage_error_led;
  logic [1:0] stall_count;
  logic [1:0] state;

  int compared   = 0;
  int mismatched = 0;

  int m_mode;
  int m_start;
  int m_stall;
  int hist[$];

  typedef struct {
    logic pump;
    int   lvl;
    logic clr;
    int   reps;
    int   st;
    int   stl;
    logic done;
    logic err;
  } vec_t;

  vec_t vecs[$];

  drain_flow_monitor #(
    .CHECK_PERIOD (CP),
    .MIN_DROP     (MD),
    .STALL_LIMIT  (SL),
    .EMPTY_LEVEL  (EL),
    .EMPTY_CONFIRM(EC),
    .TIMEOUT      (TO)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .drain_pump        (drain_pump),
    .water_level_sensor(water_level_sensor),
    .clear_error       (clear_error),
    .drain_done        (drain_done),
    .error_flag        (error_flag),
    .drainage_error_led(drainage_error_led),
    .stall_count       (stall_count),
    .state             (state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic model_reset();
    m_mode  = 0;
    m_start = 0;
    m_stall = 0;
    hist.delete();
  endtask

  // Recomputes the drain verdict from the whole level history of the session.
  task automatic model_edge(input logic p, input int lv, input logic c);
    int n;
    int run;
    int fails;
    int refl;
    int cur;
    int dv;
    case (m_mode)
      0: begin
        if (p) begin
          m_mode  = 1;
          m_start = lv;
          m_stall = 0;
          hist.delete();
        end
      end
      1: begin
        if (!p) begin
          m_mode  = 0;
          m_stall = 0;
        end else begin
          hist.push_back(lv);
          n   = hist.size();
          run = 0;
          for (int i = n - 1; i >= 0 && hist[i] <= EL; i--) run++;
          fails = 0;
          for (int k = 1; k <= n / CP; k++) begin
            refl = (k == 1) ? m_start : hist[(k - 1) * CP - 1];
            cur  = hist[k * CP - 1];
            dv   = (refl > cur) ? refl - cur : 0;
            if (dv < MD) fails++;
            else fails = 0;
          end
          m_stall = (fails > SL) ? SL : fails;
          if (run >= EC) m_mode = 2;
          else if ((n % CP == 0) && fails >= SL) m_mode = 3;
          else if (n >= TO) m_mode = 3;
        end
      end
      2: begin
        if (!p) begin
          m_mode  = 0;
          m_stall = 0;
        end
      end
      default: begin
        if (c && !p) begin
          m_mode  = 0;
          m_stall = 0;
        end
      end
    endcase
  endtask

  task automatic chk(input string nm, input int st, input int stl,
                     input logic dn, input logic er);
    compared++;
    if (state !== 2'(st) || stall_count !== 2'(stl) ||
        drain_done !== dn || error_flag !== er ||
        drainage_error_led !== er) begin
      mismatched++;
      $display("FAIL %s @%0t: got st=%0d stall=%0d done=%b err=%b led=%b, want st=%0d stall=%0d done=%b err=%b",
               nm, $time, state, stall_count, drain_done, error_flag,
               drainage_error_led, st, stl, dn, er);
    end
  endtask

  task automatic step(input logic p, input int lv, input logic c);
    drain_pump         = p;
    water_level_sensor = 10'(lv);
    clear_error        = c;
    @(posedge clk);
    model_edge(p, lv, c);
    #1;
    chk("model", m_mode, m_stall, m_mode == 2, m_mode == 3);
  endtask

  task automatic do_reset();
    reset              = 1'b0;
    drain_pump         = 1'b0;
    clear_error        = 1'b0;
    water_level_sensor = '0;
    model_reset();
    @(negedge clk);
    #1;
    chk("reset", 0, 0, 1'b0, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    model_edge(1'b0, 0, 1'b0);
    #1;
  endtask

  task automatic add(input logic p, input int l, input logic c, input int r,
                     input int st, input int stl, input logic dn, input logic er);
    vec_t v;
    v.pump = p;
    v.lvl  = l;
    v.clr  = c;
    v.reps = r;
    v.st   = st;
    v.stl  = stl;
    v.done = dn;
    v.err  = er;
    vecs.push_back(v);
  endtask

  initial begin
    int lv;
    int rate;
    logic p;
    logic c;
    int drops[4];
    int exps[4];

    // normal drain
    add(1, 300, 0, 1,  1, 0, 0, 0);
    add(1, 300, 0, 9,  1, 0, 0, 0);
    add(1, 250, 0, 10, 1, 0, 0, 0);
    add(1, 8,   0, 3,  1, 0, 0, 0);
    add(1, 8,   0, 1,  2, 0, 1, 0);
    add(1, 50,  0, 2,  2, 0, 1, 0);
    add(0, 50,  0, 1,  0, 0, 0, 0);
    // blocked drain
    add(1, 300, 0, 1,  1, 0, 0, 0);
    add(1, 300, 0, 10, 1, 1, 0, 0);
    add(1, 300, 0, 10, 1, 2, 0, 0);
    add(1, 300, 0, 9,  1, 2, 0, 0);
    add(1, 300, 0, 1,  3, 3, 0, 1);
    add(0, 300, 0, 2,  3, 3, 0, 1);
    add(1, 300, 0, 1,  3, 3, 0, 1);
    add(0, 300, 1, 1,  0, 0, 0, 0);
    // pause and restart
    add(1, 300, 0, 1,  1, 0, 0, 0);
    add(1, 300, 0, 15, 1, 1, 0, 0);
    add(0, 300, 0, 1,  0, 0, 0, 0);
    add(1, 200, 0, 1,  1, 0, 0, 0);
    add(1, 200, 0, 9,  1, 0, 0, 0);
    add(1, 200, 0, 1,  1, 1, 0, 0);
    add(0, 200, 0, 1,  0, 0, 0, 0);

    do_reset();

    foreach (vecs[i]) begin
      for (int r = 0; r < vecs[i].reps; r++)
        step(vecs[i].pump, vecs[i].lvl, vecs[i].clr);
      chk($sformatf("vec%0d", i), vecs[i].st, vecs[i].stl,
          vecs[i].done, vecs[i].err);
    end

    // MIN_DROP boundary: 4 fails, 5 passes
    drops = '{4, 5, 4, 5};
    exps  = '{1, 0, 1, 0};
    lv = 500;
    step(1'b1, lv, 1'b0);
    for (int k = 0; k < 4; k++) begin
      lv = lv - drops[k];
      repeat (CP) step(1'b1, lv, 1'b0);
      chk($sformatf("mindrop%0d", k), 1, exps[k], 1'b0, 1'b0);
    end
    step(1'b0, lv, 1'b0);
    lv = 500;
    step(1'b1, lv, 1'b0);
    for (int k = 0; k < 3; k++) begin
      lv = lv - 4;
      repeat (CP) step(1'b1, lv, 1'b0);
      chk($sformatf("drop4_%0d", k), (k < 2) ? 1 : 3, k + 1, 1'b0, k == 2);
    end
    step(1'b0, lv, 1'b1);
    chk("drop4_clear", 0, 0, 1'b0, 1'b0);

    // timeout while still flowing
    step(1'b1, 1000, 1'b0);
    for (int e = 1; e <= TO; e++) begin
      step(1'b1, 1000 - 5 * ((e + 9) / 10), 1'b0);
      if (e == TO - 1) chk("timeout_pre", 1, 0, 1'b0, 1'b0);
    end
    chk("timeout", 3, 0, 1'b0, 1'b1);
    step(1'b0, 700, 1'b1);
    chk("timeout_clear", 0, 0, 1'b0, 1'b0);

    // clear handling and asynchronous reset
    repeat (CP * SL + 1) step(1'b1, 300, 1'b0);
    chk("err6", 3, 3, 1'b0, 1'b1);
    step(1'b1, 300, 1'b1);
    chk("clr_pump_on", 3, 3, 1'b0, 1'b1);
    step(1'b0, 300, 1'b1);
    chk("clr_idle", 0, 0, 1'b0, 1'b0);
    repeat (CP * SL + 1) step(1'b1, 300, 1'b0);
    chk("err6b", 3, 3, 1'b0, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    chk("async_reset", 0, 0, 1'b0, 1'b0);
    do_reset();

    // randomized sessions
    lv   = 400;
    rate = 1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (m_mode == 0) begin
        lv   = $urandom_range(100, 700);
        rate = $urandom_range(0, 3);
      end
      if (m_mode == 3) p = $urandom_range(0, 1) == 1;
      else if (m_mode == 2) p = $urandom_range(0, 9) != 0;
      else p = $urandom_range(0, 39) != 0;
      c = $urandom_range(0, 7) == 0;
      if ($urandom_range(0, 15) == 0) lv = lv + $urandom_range(0, 30);
      else lv = lv - $urandom_range(0, rate);
      if (lv < 0) lv = 0;
      if (lv > 1023) lv = 1023;
      step(p, lv, c);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
